// File: rtl/prog_clock_divider.sv
// Programmable multi-channel clock divider. Each channel divides clock_in by
// a run-time divisor D and produces a high phase of H cycles at the end of
// each period, plus a one-cycle tick in the last cycle of the period.
// New D/H settings are loaded into a shadow copy and take effect at the next
// period boundary, so a running period is never cut short or stretched.
//
// Parameters: WIDTH (counter/divisor bits), CHANNELS, DEFAULT_DIVISOR.
// Ports:
//   clock_in    sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   enable      per-channel run enable
//   load        per-channel strobe capturing divisor_in/high_in
//   divisor_in  packed divisors, channel i at [i*WIDTH +: WIDTH]
//   high_in     packed high-phase lengths, same packing
//   clock_out   registered divided clock per channel
//   tick_out    pulse in the last cycle of each period
//   pending     a loaded setting is waiting for its period boundary
// Optional macro CLKDIV_SYNC_EN adds input sync_in, which restarts every
// enabled channel at count 0 and applies any pending setting.

module prog_clock_divider #(
    parameter int WIDTH           = 28,
    parameter int CHANNELS        = 2,
    parameter int DEFAULT_DIVISOR = 6
) (
    input  logic                      clock_in,
    input  logic                      reset_n,
`ifdef CLKDIV_SYNC_EN
    input  logic                      sync_in,
`endif
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] divisor_in,
    input  logic [CHANNELS*WIDTH-1:0] high_in,
    output logic [CHANNELS-1:0]       clock_out,
    output logic [CHANNELS-1:0]       tick_out,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    // Divisors below 2 cannot form a period with both phases; treat as 2.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    // Length of the low phase: count value at which clock_out goes high.
    // H=0 means a 50/50 split; H >= Deff is clamped so one low cycle remains.
    function automatic logic [WIDTH-1:0] low_len(
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] h
    );
        logic [WIDTH-1:0] de;
        logic [WIDTH-1:0] he;
        de = eff_div(d);
        if (h == '0) begin
            he = de >> 1;
        end else if (h >= de) begin
            he = de - ONE;
        end else begin
            he = h;
        end
        return de - he;
    endfunction

    logic sync;
`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] d_act;
        logic [WIDTH-1:0] h_act;
        logic [WIDTH-1:0] d_sh;
        logic [WIDTH-1:0] h_sh;
        logic [WIDTH-1:0] cnt;
        logic             pend;
        logic             clk_q;

        logic [WIDTH-1:0] d_nx;
        logic [WIDTH-1:0] h_nx;
        logic [WIDTH-1:0] cnt_nx;
        logic             pend_nx;
        logic             clk_nx;

        logic [WIDTH-1:0] d_new;
        logic [WIDTH-1:0] h_new;
        logic             wrap;

        assign d_new = divisor_in[i*WIDTH +: WIDTH];
        assign h_new = high_in[i*WIDTH +: WIDTH];

        // >= rather than == keeps the counter bounded even if D shrinks.
        assign wrap = (cnt >= eff_div(d_act) - ONE);

        always_comb begin
            d_nx    = d_act;
            h_nx    = h_act;
            pend_nx = pend;
            cnt_nx  = cnt + ONE;
            if (!enable[i]) begin
                // Idle: no period in flight, so settings apply at once.
                cnt_nx  = '0;
                pend_nx = 1'b0;
                if (load[i]) begin
                    d_nx = d_new;
                    h_nx = h_new;
                end else if (pend) begin
                    d_nx = d_sh;
                    h_nx = h_sh;
                end
            end else if (sync) begin
                // Restart: the old shadow goes live, a same-edge load waits.
                cnt_nx  = '0;
                pend_nx = load[i];
                if (pend) begin
                    d_nx = d_sh;
                    h_nx = h_sh;
                end
            end else if (wrap) begin
                cnt_nx  = '0;
                pend_nx = 1'b0;
                if (load[i]) begin
                    d_nx = d_new;
                    h_nx = h_new;
                end else if (pend) begin
                    d_nx = d_sh;
                    h_nx = h_sh;
                end
            end else if (load[i]) begin
                pend_nx = 1'b1;
            end
            // Output flop follows the count it will accompany next cycle.
            clk_nx = (cnt_nx >= low_len(d_nx, h_nx));
        end

        always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
                d_act <= DEF_D;
                h_act <= '0;
                d_sh  <= DEF_D;
                h_sh  <= '0;
                cnt   <= '0;
                pend  <= 1'b0;
                clk_q <= 1'b0;
            end else begin
                d_act <= d_nx;
                h_act <= h_nx;
                cnt   <= cnt_nx;
                pend  <= pend_nx;
                clk_q <= clk_nx;
                if (load[i]) begin
                    d_sh <= d_new;
                    h_sh <= h_new;
                end
            end
        end

        assign clock_out[i] = clk_q;
        assign tick_out[i]  = enable[i] & wrap;
        assign pending[i]   = pend;
    end

endmodule
